// File: rtl/sha_packet_arbiter.sv
// sha_packet_arbiter: packet-granular round-robin sharing of one sha256 engine among N_REQ requesters,
// with a tag FIFO that routes each digest back to the requester that was granted for it.
module sha_packet_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 512,
    parameter int TID_WIDTH  = 6,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [N_REQ-1:0]                    s_req_tvalid,
    output logic [N_REQ-1:0]                    s_req_tready,
    input  logic [N_REQ*DATA_WIDTH-1:0]         s_req_tdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]       s_req_tkeep,
    input  logic [N_REQ*TID_WIDTH-1:0]          s_req_tid,
    input  logic [N_REQ-1:0]                    s_req_tlast,
    output logic                                m_eng_tvalid,
    input  logic                                m_eng_tready,
    output logic [DATA_WIDTH-1:0]               m_eng_tdata,
    output logic [DATA_WIDTH/8-1:0]             m_eng_tkeep,
    output logic [TID_WIDTH-1:0]                m_eng_tid,
    output logic                                m_eng_tlast,
    input  logic                                s_res_tvalid,
    output logic                                s_res_tready,
    input  logic [DATA_WIDTH-1:0]               s_res_tdata,
    input  logic [DATA_WIDTH/8-1:0]             s_res_tkeep,
    input  logic [TID_WIDTH-1:0]                s_res_tid,
    input  logic                                s_res_tlast,
    output logic [N_REQ-1:0]                    m_rsp_tvalid,
    input  logic [N_REQ-1:0]                    m_rsp_tready,
    output logic [N_REQ*DATA_WIDTH-1:0]         m_rsp_tdata,
    output logic [N_REQ*DATA_WIDTH/8-1:0]       m_rsp_tkeep,
    output logic [N_REQ*TID_WIDTH-1:0]          m_rsp_tid,
    output logic [N_REQ-1:0]                    m_rsp_tlast,
    output logic [$clog2(N_REQ)-1:0]            grant_idx,
    output logic                                busy
);
    localparam int GW = $clog2(N_REQ);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [GW-1:0]  rr_ptr, pick, idx, head;
    logic [GW-1:0]  mem [TAG_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           tag_empty, tag_full, push, pop, sel, eng_end;

    // Scanning from the farthest offset down leaves the nearest valid requester after rr_ptr in pick
    always_comb begin
        pick = rr_ptr;
        idx  = rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_ptr) + i) % N_REQ);
            if (s_req_tvalid[idx]) pick = idx;
        end
    end

    assign tag_empty = count == '0;
    assign tag_full  = count == CW'(TAG_DEPTH);
    assign head      = mem[rd_ptr];
    assign sel       = state == BUSY;
    assign push      = !sel && |s_req_tvalid && !tag_full;
    assign pop       = s_res_tvalid && s_res_tready && s_res_tlast;
    assign eng_end   = m_eng_tvalid && m_eng_tready && m_eng_tlast;

    assign m_eng_tvalid = sel && s_req_tvalid[grant_idx];
    assign m_eng_tdata  = s_req_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign m_eng_tkeep  = s_req_tkeep[grant_idx*KW +: KW];
    assign m_eng_tid    = s_req_tid[grant_idx*TID_WIDTH +: TID_WIDTH];
    assign m_eng_tlast  = s_req_tlast[grant_idx];

    always_comb begin
        s_req_tready = '0;
        m_rsp_tvalid = '0;
        if (sel) s_req_tready[grant_idx] = m_eng_tready;
        if (!tag_empty) m_rsp_tvalid[head] = s_res_tvalid;
    end

    assign s_res_tready = m_rsp_tready[head] && !tag_empty;
    assign m_rsp_tdata  = {N_REQ{s_res_tdata}};
    assign m_rsp_tkeep  = {N_REQ{s_res_tkeep}};
    assign m_rsp_tid    = {N_REQ{s_res_tid}};
    assign m_rsp_tlast  = {N_REQ{s_res_tlast}};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                grant_idx <= pick;
                state     <= BUSY;
                busy      <= 1'b1;
            end else if (sel && eng_end) begin
                rr_ptr <= grant_idx == GW'(N_REQ - 1) ? '0 : grant_idx + 1'b1;
                state  <= IDLE;
                busy   <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= pick;
    end
endmodule

// File: tb/tb_sha_packet_arbiter.sv
// tb_sha_packet_arbiter: directed scenarios with a queue-based reference model checked every cycle.
module tb_sha_packet_arbiter;
    localparam int N = 2, DW = 512, KW = 64, IW = 6, DEPTH = 8;

    logic aclk = 1'b0, areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [N-1:0] s_req_tvalid, s_req_tready, s_req_tlast, m_rsp_tvalid, m_rsp_tready, m_rsp_tlast;
    logic [N*DW-1:0] s_req_tdata, m_rsp_tdata;
    logic [N*KW-1:0] s_req_tkeep, m_rsp_tkeep;
    logic [N*IW-1:0] s_req_tid, m_rsp_tid;
    logic m_eng_tvalid, m_eng_tready, m_eng_tlast, s_res_tvalid, s_res_tready, s_res_tlast;
    logic [DW-1:0] m_eng_tdata, s_res_tdata;
    logic [KW-1:0] m_eng_tkeep, s_res_tkeep;
    logic [IW-1:0] m_eng_tid, s_res_tid;
    logic [0:0] grant_idx;
    logic busy;

    sha_packet_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TID_WIDTH(IW), .TAG_DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready), .s_req_tdata(s_req_tdata),
        .s_req_tkeep(s_req_tkeep), .s_req_tid(s_req_tid), .s_req_tlast(s_req_tlast),
        .m_eng_tvalid(m_eng_tvalid), .m_eng_tready(m_eng_tready), .m_eng_tdata(m_eng_tdata),
        .m_eng_tkeep(m_eng_tkeep), .m_eng_tid(m_eng_tid), .m_eng_tlast(m_eng_tlast),
        .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready), .s_res_tdata(s_res_tdata),
        .s_res_tkeep(s_res_tkeep), .s_res_tid(s_res_tid), .s_res_tlast(s_res_tlast),
        .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tready(m_rsp_tready), .m_rsp_tdata(m_rsp_tdata),
        .m_rsp_tkeep(m_rsp_tkeep), .m_rsp_tid(m_rsp_tid), .m_rsp_tlast(m_rsp_tlast),
        .grant_idx(grant_idx), .busy(busy)
    );

    int vectors = 0, miscompares = 0;
    int npk[N], len[N], beat[N], pkt[N];
    bit en[N], hs_req[N];
    bit eng_rdy, res_en, hs_res;
    logic [N-1:0] rsp_rdy;
    int res_len, rbeat, eng_beats;
    int eng_q[$], eng_pk[$], rsp_log[$];
    int own, g, rr, tags[$];
    logic [N-1:0] er, ev;
    logic es;
    int h, p, sz, c, r;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] src(input int i, input int pk, input int b);
        return {16{8'(i + 1), 8'(pk), 8'(b), 8'h5A}};
    endfunction

    function automatic logic [DW-1:0] dig(input int e, input int b);
        return {16{8'hD0 + 8'(b), 8'(e & 255), 8'(e >> 8) + 8'd1, 8'h3C}};
    endfunction

    // Packs a small log of lane numbers into hex digits (lane+1) for literal comparison
    function automatic int enc(input int q[$]);
        int v = 0;
        foreach (q[k]) v = v * 16 + q[k] + 1;
        return v;
    endfunction

    task automatic apply();
        int e = 0;
        for (int i = 0; i < N; i++) begin
            s_req_tvalid[i] = en[i] && npk[i] > 0;
            s_req_tdata[i*DW +: DW] = src(i, pkt[i], beat[i]);
            s_req_tkeep[i*KW +: KW] = {KW{1'b1}} >> beat[i];
            s_req_tid[i*IW +: IW] = IW'(i * 16 + pkt[i]);
            s_req_tlast[i] = beat[i] == len[i] - 1;
        end
        m_eng_tready = eng_rdy;
        m_rsp_tready = rsp_rdy;
        if (eng_q.size() > 0) e = eng_q[0];
        s_res_tvalid = res_en && eng_q.size() > 0;
        s_res_tdata = dig(e, rbeat);
        s_res_tkeep = {KW{1'b1}};
        s_res_tid = IW'(e);
        s_res_tlast = rbeat == res_len - 1;
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (hs_req[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]++;
                    npk[i]--;
                end else beat[i]++;
            end
            hs_req[i] = 1'b0;
        end
        if (hs_res) begin
            if (rbeat == res_len - 1) begin
                rbeat = 0;
                void'(eng_q.pop_front());
            end else rbeat++;
        end
        hs_res = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
            advance();
            apply();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int i = 0; i < N; i++) begin
            npk[i] = 0; len[i] = 1; beat[i] = 0; pkt[i] = 0; en[i] = 1'b0; hs_req[i] = 1'b0;
        end
        eng_rdy = 1'b1; res_en = 1'b1; rsp_rdy = '1; res_len = 1; rbeat = 0; hs_res = 1'b0; eng_beats = 0;
        eng_q.delete(); eng_pk.delete(); rsp_log.delete();
        apply();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // Reference model: one owner at a time, round-robin pointer, FIFO of outstanding owners
    always @(negedge aclk) begin
        if (areset) begin
            chk("rst_eng_tvalid", m_eng_tvalid, 0);
            chk("rst_req_tready", s_req_tready, 0);
            chk("rst_rsp_tvalid", m_rsp_tvalid, 0);
            chk("rst_res_tready", s_res_tready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant_idx, 0);
            own = -1; g = 0; rr = 0;
            tags.delete();
        end else begin
            er = '0; ev = '0; es = 1'b0;
            if (own >= 0) er[own] = m_eng_tready;
            chk("eng_tvalid", m_eng_tvalid, own >= 0 && s_req_tvalid[own]);
            if (own >= 0 && s_req_tvalid[own]) begin
                chk("eng_tdata", m_eng_tdata, s_req_tdata[own*DW +: DW]);
                chk("eng_tkeep", m_eng_tkeep, s_req_tkeep[own*KW +: KW]);
                chk("eng_tid", m_eng_tid, s_req_tid[own*IW +: IW]);
                chk("eng_tlast", m_eng_tlast, s_req_tlast[own]);
            end
            chk("req_tready", s_req_tready, er);
            chk("busy", busy, own >= 0);
            chk("grant_idx", grant_idx, g);
            if (tags.size() > 0) begin
                h = tags[0];
                ev[h] = s_res_tvalid;
                es = m_rsp_tready[h];
            end
            chk("rsp_tvalid", m_rsp_tvalid, ev);
            chk("res_tready", s_res_tready, es);
            if (ev != 0) begin
                chk("rsp_tdata", m_rsp_tdata[h*DW +: DW], s_res_tdata);
                chk("rsp_tkeep", m_rsp_tkeep[h*KW +: KW], s_res_tkeep);
                chk("rsp_tid", m_rsp_tid[h*IW +: IW], s_res_tid);
                chk("rsp_tlast", m_rsp_tlast[h], s_res_tlast);
            end
            for (int i = 0; i < N; i++) hs_req[i] = s_req_tvalid[i] && s_req_tready[i];
            hs_res = s_res_tvalid && s_res_tready;
            if (m_eng_tvalid && m_eng_tready) begin
                eng_beats++;
                if (m_eng_tlast) begin
                    r = int'(m_eng_tdata[31:24]) - 1;
                    eng_pk.push_back(r);
                    eng_q.push_back(r * 256 + int'(m_eng_tdata[23:16]));
                end
            end
            for (int l = 0; l < N; l++)
                if (m_rsp_tvalid[l] && m_rsp_tready[l] && m_rsp_tlast[l]) begin
                    rsp_log.push_back(l);
                    chk("rsp_route", m_rsp_tdata[l*DW+8 +: 8], 8'(l + 1));
                end
            sz = tags.size();
            if (own < 0) begin
                if (s_req_tvalid != 0 && sz < DEPTH) begin
                    p = -1;
                    for (int k = 0; k < N; k++) begin
                        c = (rr + k) % N;
                        if (p < 0 && s_req_tvalid[c]) p = c;
                    end
                    own = p; g = p;
                    tags.push_back(p);
                end
            end else if (s_req_tvalid[own] && m_eng_tready && s_req_tlast[own]) begin
                rr = (own + 1) % N;
                own = -1;
            end
            if (sz > 0 && s_res_tvalid && m_rsp_tready[tags[0]] && s_res_tlast) void'(tags.pop_front());
        end
    end

    initial begin
        // 1: single 3-beat packet from requester 0, one bubble, digest on lane 0
        do_reset();
        npk[0] = 1; len[0] = 3; en[0] = 1'b1;
        apply();
        chk("t1_bubble_tvalid", m_eng_tvalid, 0);
        chk("t1_bubble_busy", busy, 0);
        step(1);
        chk("t1_first_tvalid", m_eng_tvalid, 1);
        chk("t1_first_busy", busy, 1);
        step(10);
        chk("t1_beats", eng_beats, 3);
        chk("t1_rsp_lanes", enc(rsp_log), 32'h1);
        // 2: both requesters busy, packets alternate
        do_reset();
        npk[0] = 2; npk[1] = 2; len[0] = 2; len[1] = 2; en[0] = 1'b1; en[1] = 1'b1;
        apply();
        step(25);
        chk("t2_eng_order", enc(eng_pk), 32'h1212);
        chk("t2_rsp_order", enc(rsp_log), 32'h1212);
        // 3: engine stalls during requester 0 packet; requester 1 must wait
        do_reset();
        npk[0] = 1; len[0] = 4; npk[1] = 1; len[1] = 2; en[0] = 1'b1; en[1] = 1'b1;
        apply();
        step(1);
        eng_rdy = 1'b0;
        apply();
        step(5);
        chk("t3_grant", grant_idx, 0);
        chk("t3_busy", busy, 1);
        chk("t3_beats", eng_beats, 0);
        chk("t3_tready", s_req_tready, 0);
        eng_rdy = 1'b1;
        apply();
        step(20);
        chk("t3_eng_order", enc(eng_pk), 32'h12);
        // 4: tag FIFO fills at 8, ninth waits until one pop
        do_reset();
        res_en = 1'b0;
        npk[0] = 5; npk[1] = 5; en[0] = 1'b1; en[1] = 1'b1;
        apply();
        step(25);
        chk("t4_granted", eng_pk.size(), 8);
        chk("t4_full_busy", busy, 0);
        chk("t4_full_grant", grant_idx, 1);
        res_en = 1'b1;
        apply();
        step(1);
        res_en = 1'b0;
        apply();
        chk("t4_pop_busy", busy, 0);
        step(1);
        chk("t4_ninth_busy", busy, 1);
        chk("t4_ninth_grant", grant_idx, 0);
        res_en = 1'b1;
        apply();
        step(40);
        chk("t4_total_pkts", eng_pk.size(), 10);
        chk("t4_total_rsp", rsp_log.size(), 10);
        // 5: lane 1 backpressure holds a two-beat digest at the head
        do_reset();
        res_len = 2; rsp_rdy = 2'b01;
        npk[1] = 1; npk[0] = 1; en[1] = 1'b1;
        apply();
        step(6);
        en[0] = 1'b1;
        apply();
        step(6);
        chk("t5_res_tready", s_res_tready, 0);
        chk("t5_rsp_tvalid", m_rsp_tvalid, 2'b10);
        step(3);
        chk("t5_hold", m_rsp_tdata[DW +: DW], dig(256, 0));
        rsp_rdy = 2'b11;
        apply();
        step(12);
        chk("t5_rsp_order", enc(rsp_log), 32'h21);
        // 6: asynchronous reset in the middle of requester 1 packet
        do_reset();
        npk[0] = 1; npk[1] = 1; len[1] = 4; en[0] = 1'b1; en[1] = 1'b1;
        apply();
        step(4);
        chk("t6_pre_grant", grant_idx, 1);
        chk("t6_pre_tvalid", m_eng_tvalid, 1);
        #2 areset = 1'b1;
        #1;
        chk("t6_async_eng_tvalid", m_eng_tvalid, 0);
        chk("t6_async_req_tready", s_req_tready, 0);
        chk("t6_async_busy", busy, 0);
        do_reset();
        npk[0] = 1; npk[1] = 1; len[0] = 2; len[1] = 2; en[0] = 1'b1; en[1] = 1'b1;
        apply();
        step(1);
        chk("t6_restart_grant", grant_idx, 0);
        chk("t6_restart_busy", busy, 1);
        step(15);
        chk("t6_eng_order", enc(eng_pk), 32'h12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
